// File: rtl/riscv_structures.sv
// Shared pipeline-control types and constants.
//   fwd_sel_e    : execute operand source select (register file / mem-stage / wb)
//   ctrl_state_e : pipeline controller sequencing states
//   pick_fwd()   : nearest-producer forwarding priority for one source operand
package riscv_structures;

  localparam int REG_ADDR_W  = 5;
  localparam int FLUSH_CNT_W = 3;

  // Source operand indices
  localparam int NUM_SRC  = 2;
  localparam int SRC_RS1  = 0;
  localparam int SRC_RS2  = 1;

  // Producer stage indices
  localparam int NUM_PROD = 3;
  localparam int PROD_EX  = 0;
  localparam int PROD_MEM = 1;
  localparam int PROD_WB  = 2;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // operand from register file
    FWD_MEM = 2'b01,  // result now sitting in the memory stage
    FWD_WB  = 2'b10   // result now sitting in writeback
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10
  } ctrl_state_e;

  // The instruction currently in EX is the nearest producer: when it is an
  // ALU op its result will be in MEM next cycle. A load in EX cannot be
  // forwarded (that case is a load-use stall), so fall through to MEM.
  function automatic fwd_sel_e pick_fwd(input logic hit_ex,
                                        input logic ex_is_load,
                                        input logic hit_mem);
    if (hit_ex && !ex_is_load) begin
      return FWD_MEM;
    end else if (hit_mem) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational RAW match of one decode source against one producer stage.
// Ports:
//   id_valid   in  decode holds a valid instruction
//   src_used   in  the source register is actually read
//   src_reg    in  source register index
//   prod_write in  producer writes the register file
//   prod_rd    in  producer destination index
//   hit        out dependency exists (x0 never matches)
module hazard_match
  import riscv_structures::*;
(
  input  logic                  id_valid,
  input  logic                  src_used,
  input  logic [REG_ADDR_W-1:0] src_reg,
  input  logic                  prod_write,
  input  logic [REG_ADDR_W-1:0] prod_rd,
  output logic                  hit
);

  assign hit = id_valid && src_used && prod_write &&
               (prod_rd != '0) && (prod_rd == src_reg);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard / flush controller for a 5-stage in-order pipeline.
// Produces stall and flush strobes combinationally from the current state and
// the decode/producer fields, registers the execute forwarding selects, and
// keeps a saturating count of stall cycles.
//
// Build option: PIPELINE_CTRL_FORWARDING_EN
//   defined   : EX/MEM forwarding; only a load-use dependency stalls (one
//               cycle, followed by a LOAD_STALL cycle).
//   undefined : no forwarding; any dependency on EX/MEM/WB stalls for as long
//               as it persists, and the forwarding selects stay at 00.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   id_valid, id_rs1/2, id_uses_rs1/2   decode-stage operand info
//   ex_rd, ex_reg_write, ex_mem_read    execute-stage producer
//   mem_rd, mem_reg_write               memory-stage producer
//   wb_rd, wb_reg_write                 writeback-stage producer
//   branch_taken                        execute redirect
//   stall_if, stall_id                  hold PC / decode register
//   flush_id, flush_ex                  squash decode / bubble into execute
//   fwd_rs1_sel, fwd_rs2_sel            registered execute operand selects
//   stall_cnt                           saturating stall-cycle count
module pipeline_ctrl
  import riscv_structures::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  // Branch cycle itself is the first bubble; FLUSH covers the remainder.
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam ctrl_state_e BRANCH_STATE = (FLUSH_CYCLES == 1) ? RUN : FLUSH;

  // ---------------------------------------------------------------- matching
  logic [REG_ADDR_W-1:0] src_reg    [NUM_SRC];
  logic                  src_used   [NUM_SRC];
  logic [REG_ADDR_W-1:0] prod_rd    [NUM_PROD];
  logic                  prod_write [NUM_PROD];
  logic                  hit        [NUM_SRC][NUM_PROD];

  assign src_reg[SRC_RS1]     = id_rs1;
  assign src_reg[SRC_RS2]     = id_rs2;
  assign src_used[SRC_RS1]    = id_uses_rs1;
  assign src_used[SRC_RS2]    = id_uses_rs2;
  assign prod_rd[PROD_EX]     = ex_rd;
  assign prod_rd[PROD_MEM]    = mem_rd;
  assign prod_rd[PROD_WB]     = wb_rd;
  assign prod_write[PROD_EX]  = ex_reg_write;
  assign prod_write[PROD_MEM] = mem_reg_write;
  assign prod_write[PROD_WB]  = wb_reg_write;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      for (gj = 0; gj < NUM_PROD; gj++) begin : g_prod
        hazard_match u_match (
          .id_valid  (id_valid),
          .src_used  (src_used[gi]),
          .src_reg   (src_reg[gi]),
          .prod_write(prod_write[gj]),
          .prod_rd   (prod_rd[gj]),
          .hit       (hit[gi][gj])
        );
      end
    end
  endgenerate

  logic        hit_ex_any;
  logic        stall_req;
  ctrl_state_e stall_state;

  assign hit_ex_any = hit[SRC_RS1][PROD_EX] | hit[SRC_RS2][PROD_EX];

`ifdef PIPELINE_CTRL_FORWARDING_EN
  // WB results are assumed written through the register file in time.
  logic unused_wb_hits;
  assign unused_wb_hits = hit[SRC_RS1][PROD_WB] | hit[SRC_RS2][PROD_WB];
  assign stall_req      = hit_ex_any & ex_mem_read;
  assign stall_state    = LOAD_STALL;
`else
  logic unused_ex_mem_read;
  assign unused_ex_mem_read = ex_mem_read;
  assign stall_req   = hit_ex_any |
                       hit[SRC_RS1][PROD_MEM] | hit[SRC_RS2][PROD_MEM] |
                       hit[SRC_RS1][PROD_WB]  | hit[SRC_RS2][PROD_WB];
  assign stall_state = RUN;
`endif

  // --------------------------------------------------------------- control
  ctrl_state_e             state_reg, state_next;
  logic [FLUSH_CNT_W-1:0]  cnt_reg,   cnt_next;

  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      FLUSH: begin
        // Redirects arriving while already flushing are ignored.
        flush_id = 1'b1;
        flush_ex = 1'b1;
        if (cnt_reg <= FLUSH_CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg - FLUSH_CNT_W'(1);
        end
      end
      LOAD_STALL: begin
        if (branch_taken) begin
          flush_id   = 1'b1;
          flush_ex   = 1'b1;
          cnt_next   = FLUSH_LOAD;
          state_next = BRANCH_STATE;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        if (branch_taken) begin
          flush_id   = 1'b1;
          flush_ex   = 1'b1;
          cnt_next   = FLUSH_LOAD;
          state_next = BRANCH_STATE;
        end else if (stall_req) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          flush_ex   = 1'b1;
          state_next = stall_state;
        end
      end
    endcase
  end

  // ------------------------------------------------------------ forwarding
  fwd_sel_e fwd_next [NUM_SRC];

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
`ifdef PIPELINE_CTRL_FORWARDING_EN
      // A bubble or a held decode must not carry a stale select into EX.
      assign fwd_next[gi] = (flush_ex || stall_id) ? FWD_RF :
                            pick_fwd(hit[gi][PROD_EX], ex_mem_read,
                                     hit[gi][PROD_MEM]);
`else
      assign fwd_next[gi] = FWD_RF;
`endif
    end
  endgenerate

  // ------------------------------------------------------------- registers
  fwd_sel_e         fwd_rs1_reg, fwd_rs2_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      cnt_reg       <= '0;
      fwd_rs1_reg   <= FWD_RF;
      fwd_rs2_reg   <= FWD_RF;
      stall_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      fwd_rs1_reg <= fwd_next[SRC_RS1];
      fwd_rs2_reg <= fwd_next[SRC_RS2];
      if (stall_id && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign fwd_rs1_sel = fwd_rs1_reg;
  assign fwd_rs2_sel = fwd_rs2_reg;
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning bubble cycles inserted after a taken branch (legal range 1..7).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the stall-cycle counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-004 SHALL have these ports:
- id_valid  in  1  valid instruction in decode
- id_rs1, id_rs2  in  5  decode source registers
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- ex_rd  in  5  execute destination
- ex_reg_write, ex_mem_read  in  1  execute writes reg / is load
- mem_rd  in  5  memory-stage destination
- mem_reg_write  in  1  memory stage writes reg
- wb_rd  in  5  writeback destination
- wb_reg_write  in  1  writeback writes reg
- branch_taken  in  1  execute redirect (pc_reset)
- stall_if, stall_id  out  1  hold fetch PC / decode register
- flush_id, flush_ex  out  1  squash decode / insert bubble into execute
- fwd_rs1_sel, fwd_rs2_sel  out  2  registered execute operand select
- stall_cnt  out  CNT_W  saturating count of stall cycles

Function
REQ-005 SHALL implement FSM {RUN, LOAD_STALL, FLUSH}, with a registered state and a 3-bit flush counter.
REQ-006 A hazard match SHALL require: source used, id_valid, producer reg_write=1, and producer rd equal to the source register with rd != 0; x0 never matches.
REQ-007 In RUN with branch_taken=1, the block SHALL assert flush_id=flush_ex=1 that cycle, load cnt=FLUSH_CYCLES-1, and enter FLUSH; if FLUSH_CYCLES=1 it SHALL return to RUN.
REQ-008 In FLUSH, the block SHALL assert flush_id=flush_ex=1 and stall_*=0, decrement cnt each cycle, and go to RUN when cnt==0 on that cycle; branch_taken in FLUSH SHALL be ignored.
REQ-009 In RUN with no branch and a load-use match against ex_rd with ex_mem_read=1, the block SHALL assert stall_if=stall_id=flush_ex=1 and enter LOAD_STALL.
REQ-010 LOAD_STALL SHALL last exactly one cycle with all outputs deasserted, then go to RUN; branch_taken there SHALL take priority and behave as in REQ-007.
REQ-011 branch_taken SHALL have priority over every stall condition whenever both occur in the same cycle.
REQ-012 Stall/flush outputs SHALL be combinational from state and inputs (zero latency); fwd_*_sel SHALL be registered at clk and apply to the instruction entering execute.
REQ-013 fwd select encoding: 00 register file, 01 memory-stage result, 10 writeback result; the select captured at clk is 01 if the source matches ex_rd (non-load), else 10 if it matches mem_rd, else 00; the nearer producer SHALL win.
REQ-014 When flush_ex=1 or stall_id=1, the registered fwd selects SHALL load 00.
REQ-015 stall_cnt SHALL increment on every cycle with stall_id=1 and saturate at all-ones without wrapping.

Reset
REQ-016 While rst_n=0: state=RUN, cnt=0, fwd_*_sel=00, stall_cnt=0; combinational outputs SHALL evaluate from RUN.
REQ-017 Reset asserted mid-FLUSH or mid-LOAD_STALL SHALL abandon the sequence immediately, with no residual bubbles after release.

Configuration
REQ-018 With PIPELINE_CTRL_FORWARDING_EN defined, REQ-009..REQ-014 SHALL apply.
REQ-019 Without PIPELINE_CTRL_FORWARDING_EN, any match against ex_rd, mem_rd or wb_rd (loads included) SHALL assert stall_if=stall_id=flush_ex=1 each cycle it persists, staying in RUN; LOAD_STALL SHALL be unreachable and fwd_*_sel SHALL be held at 00.

Structure
REQ-020 A fwd_sel_e enum (2 bits) and a ctrl_state_e enum SHALL live in the shared riscv_structures package.
REQ-021 A combinational sub-module hazard_match SHALL compare one source against one producer; the block SHALL instantiate it per source/producer pair.

Verification
REQ-022 Load x5 in EX; ID reads rs1=x5 -> one cycle stall_if=stall_id=flush_ex=1; next cycle LOAD_STALL with outputs 0; stall_cnt=1.
REQ-023 ADD x3 in EX (non-load); ID reads rs2=x3 -> no stall; fwd_rs2_sel=01 after the edge.
REQ-024 ex_rd=mem_rd=x7, both writing; ID reads x7 -> fwd select 01, not 10.
REQ-025 branch_taken=1 together with a load-use match, FLUSH_CYCLES=2 -> flush_id=flush_ex=1 for exactly 2 cycles, no stall, stall_cnt unchanged.
REQ-026 Producer rd=x0 with reg_write=1 -> no stall, select 00; rst_n low during the FLUSH first cycle -> after release flush_*=0.
REQ-027 Macro undefined, wb_rd=x9 writing; ID reads x9 -> stall for that cycle, fwd selects 00.
